sdfm_data_sched: RTL and testbench

- Multi-channel result scheduler for the sigma-delta filter module.
- Captures each channel's filter result on its `filt_data_update` pulse and holds it in a per-channel holding register.
- Arbitrates round-robin between channels with pending results and presents one word at a time on a single valid/ready output port, which feeds the bus interface or DMA.
- Tracks overrun per channel: a new result arriving before the previous one was taken.

---
 rtl/sdfm_data_sched.sv | 108 ++++++++++
 tb/tb_sdfm_data_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdfm_data_sched.sv
// Multi-channel result scheduler: per-channel holding registers, round-robin
// arbitration and a single registered valid/ready output with overrun tracking.
module sdfm_data_sched #(
    parameter int NCH = 4,
    parameter int DW  = 32,
    parameter int CW  = 2
) (
    input  logic              SYSCLK,
    input  logic              SYSRSTn,
    input  logic [NCH-1:0]    chan_en,
    input  logic [NCH-1:0]    filt_data_update,
    input  logic [NCH*DW-1:0] filt_data_out,
    input  logic [NCH-1:0]    ovf_clr,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [CW-1:0]     out_chan,
    output logic [NCH-1:0]    pend,
    output logic [NCH-1:0]    ovf_flag
);

    logic [DW-1:0]  hold_q [NCH];
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] ovf_q;
    logic           out_valid_q;
    logic [DW-1:0]  out_data_q;
    logic [CW-1:0]  out_chan_q;
    logic [CW-1:0]  rr_q;

    logic [NCH-1:0] elig;
    logic [NCH-1:0] gnt;
    logic [CW-1:0]  win;
    logic [CW-1:0]  idx;
    logic           found;
    logic           load;

    // Round-robin search: CW-bit index arithmetic wraps naturally since NCH = 2**CW.
    always_comb begin
        elig  = pend_q & chan_en;
        win   = rr_q;
        idx   = rr_q;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = rr_q + CW'(i);
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        load = (!out_valid_q | out_ready) & found;
        gnt  = load ? (NCH'(1) << win) : '0;
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [DW-1:0] hold_bit_q;
        logic          pend_bit_q;
        logic          ovf_bit_q;
        logic          upd;
        logic          pend_d;
        logic          ovf_d;

        // A grant in the same cycle empties the slot first, so a fresh result is not an overrun.
        assign upd    = filt_data_update[gi] & chan_en[gi];
        assign pend_d = chan_en[gi] & (upd | (pend_bit_q & ~gnt[gi]));
        assign ovf_d  = (upd & pend_bit_q & ~gnt[gi]) | (ovf_bit_q & ~ovf_clr[gi]);

        always_ff @(posedge SYSCLK) begin
            if (!SYSRSTn) begin
                hold_bit_q <= '0;
                pend_bit_q <= 1'b0;
                ovf_bit_q  <= 1'b0;
            end else begin
                if (upd) begin
                    hold_bit_q <= filt_data_out[gi*DW +: DW];
                end
                pend_bit_q <= pend_d;
                ovf_bit_q  <= ovf_d;
            end
        end

        assign hold_q[gi] = hold_bit_q;
        assign pend_q[gi] = pend_bit_q;
        assign ovf_q[gi]  = ovf_bit_q;
    end

    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_q        <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= hold_q[win];
            out_chan_q  <= win;
            rr_q        <= win + CW'(1);
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign pend      = pend_q;
    assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_sdfm_data_sched.sv
// Bench for sdfm_data_sched: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_sdfm_data_sched;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int CW  = 2;

    logic              SYSCLK = 1'b0;
    logic              SYSRSTn;
    logic [NCH-1:0]    chan_en;
    logic [NCH-1:0]    filt_data_update;
    logic [NCH*DW-1:0] filt_data_out;
    logic [NCH-1:0]    ovf_clr;
    logic              out_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_chan;
    logic [NCH-1:0]    pend;
    logic [NCH-1:0]    ovf_flag;

    sdfm_data_sched #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
        .SYSCLK           (SYSCLK),
        .SYSRSTn          (SYSRSTn),
        .chan_en          (chan_en),
        .filt_data_update (filt_data_update),
        .filt_data_out    (filt_data_out),
        .ovf_clr          (ovf_clr),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_chan         (out_chan),
        .pend             (pend),
        .ovf_flag         (ovf_flag)
    );

    always #5 SYSCLK = ~SYSCLK;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] dv [NCH];

    logic [DW-1:0]  m_hold [NCH];
    logic [NCH-1:0] m_pend;
    logic [NCH-1:0] m_ovf;
    logic           m_ov;
    logic [DW-1:0]  m_od;
    int             m_oc;
    int             m_rr;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Behavioural reference: pick the first pending enabled channel scanning from the pointer.
    function automatic void model_step();
        logic [NCH-1:0] elig;
        int             w;
        logic           ld;
        logic           g;
        if (!SYSRSTn) begin
            for (int k = 0; k < NCH; k++) m_hold[k] = '0;
            m_pend = '0; m_ovf = '0; m_ov = 1'b0; m_od = '0; m_oc = 0; m_rr = 0;
            return;
        end
        elig = m_pend & chan_en;
        w = -1;
        for (int i = 0; i < NCH; i++) begin
            int c = (m_rr + i) % NCH;
            if (w < 0 && elig[c]) w = c;
        end
        ld = (w >= 0) && (!m_ov || out_ready);
        if (ld) begin
            m_ov = 1'b1;
            m_od = m_hold[w];
            m_oc = w;
            m_rr = (w + 1) % NCH;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        for (int k = 0; k < NCH; k++) begin
            logic set;
            g = ld && (w == k);
            set = 1'b0;
            if (!chan_en[k]) begin
                m_pend[k] = 1'b0;
            end else if (filt_data_update[k]) begin
                if (m_pend[k] && !g) set = 1'b1;
                m_hold[k] = filt_data_out[k*DW +: DW];
                m_pend[k] = 1'b1;
            end else if (g) begin
                m_pend[k] = 1'b0;
            end
            if (set) m_ovf[k] = 1'b1;
            else if (ovf_clr[k]) m_ovf[k] = 1'b0;
        end
    endfunction

    task automatic cyc(input logic rstn, input logic [NCH-1:0] en, input logic [NCH-1:0] upd,
                       input logic [NCH-1:0] clr, input logic rdy);
        SYSRSTn          = rstn;
        chan_en          = en;
        filt_data_update = upd;
        ovf_clr          = clr;
        out_ready        = rdy;
        for (int k = 0; k < NCH; k++) filt_data_out[k*DW +: DW] = dv[k];
        @(posedge SYSCLK);
        model_step();
        @(negedge SYSCLK);
        chk("m_valid", out_valid, m_ov);
        chk("m_data",  out_data,  m_od);
        chk("m_chan",  out_chan,  m_oc);
        chk("m_pend",  pend,      m_pend);
        chk("m_ovf",   ovf_flag,  m_ovf);
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) dv[k] = '0;
        m_pend = '0; m_ovf = '0; m_ov = 1'b0; m_od = '0; m_oc = 0; m_rr = 0;
        for (int k = 0; k < NCH; k++) m_hold[k] = '0;

        // Reset
        cyc(0, 4'hF, 4'h0, 4'h0, 1);
        cyc(0, 4'hF, 4'h0, 4'h0, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data,  0);
        chk("rst_chan",  out_chan,  0);
        chk("rst_pend",  pend,      0);
        chk("rst_ovf",   ovf_flag,  0);

        // Single channel
        dv[2] = 32'h0000_1234;
        cyc(1, 4'hF, 4'b0100, 4'h0, 1);
        chk("t1_pend1",  pend,      4'b0100);
        chk("t1_valid1", out_valid, 0);
        cyc(1, 4'hF, 4'h0, 4'h0, 1);
        chk("t1_valid2", out_valid, 1);
        chk("t1_data",   out_data,  32'h1234);
        chk("t1_chan",   out_chan,  2);
        chk("t1_pend2",  pend,      0);
        cyc(1, 4'hF, 4'h0, 4'h0, 1);
        chk("t1_drain",  out_valid, 0);
        chk("t1_keep",   out_data,  32'h1234);

        // Round-robin from pointer 0
        cyc(0, 4'hF, 4'h0, 4'h0, 1);
        for (int k = 0; k < NCH; k++) dv[k] = 32'hA0 + k;
        cyc(1, 4'hF, 4'hF, 4'h0, 1);
        chk("t2_pend", pend, 4'hF);
        for (int j = 0; j < NCH; j++) begin
            cyc(1, 4'hF, 4'h0, 4'h0, 1);
            chk("t2_chan", out_chan, j);
            chk("t2_data", out_data, 32'hA0 + j);
        end
        dv[0] = 32'hB0; dv[1] = 32'hB1;
        cyc(1, 4'hF, 4'b0011, 4'h0, 1);
        cyc(1, 4'hF, 4'h0, 4'h0, 1);
        chk("t2_w0", out_chan, 0);
        chk("t2_d0", out_data, 32'hB0);
        cyc(1, 4'hF, 4'h0, 4'h0, 1);
        chk("t2_w1", out_chan, 1);
        chk("t2_d1", out_data, 32'hB1);
        cyc(1, 4'hF, 4'h0, 4'h0, 1);

        // Backpressure
        dv[3] = 32'h55;
        cyc(1, 4'hF, 4'b1000, 4'h0, 0);
        cyc(1, 4'hF, 4'h0, 4'h0, 0);
        dv[0] = 32'h66;
        for (int j = 0; j < 5; j++) begin
            cyc(1, 4'hF, (j == 0) ? 4'b0001 : 4'h0, 4'h0, 0);
            chk("t3_valid", out_valid, 1);
            chk("t3_data",  out_data,  32'h55);
            chk("t3_chan",  out_chan,  3);
        end
        cyc(1, 4'hF, 4'h0, 4'h0, 1);
        chk("t3_next_data", out_data, 32'h66);
        chk("t3_next_chan", out_chan, 0);
        chk("t3_next_valid", out_valid, 1);

        // Overrun
        dv[1] = 32'h10;
        cyc(1, 4'hF, 4'b0010, 4'h0, 0);
        chk("t4_ovf0", ovf_flag, 0);
        dv[1] = 32'h11;
        cyc(1, 4'hF, 4'b0010, 4'h0, 0);
        chk("t4_ovf1", ovf_flag, 4'b0010);
        cyc(1, 4'hF, 4'h0, 4'b0010, 0);
        chk("t4_clr", ovf_flag, 0);
        dv[1] = 32'h12;
        cyc(1, 4'hF, 4'b0010, 4'b0010, 0);
        chk("t4_setwins", ovf_flag, 4'b0010);
        cyc(1, 4'hF, 4'h0, 4'h0, 1);
        chk("t4_data", out_data, 32'h12);
        chk("t4_chan", out_chan, 1);
        cyc(1, 4'hF, 4'h0, 4'b0010, 0);

        // Enable
        dv[2] = 32'h20;
        cyc(1, 4'hF, 4'b0100, 4'h0, 0);
        chk("t5_pend", pend, 4'b0100);
        cyc(1, 4'b1011, 4'h0, 4'h0, 0);
        chk("t5_dis", pend, 0);
        cyc(1, 4'b1011, 4'b0100, 4'h0, 0);
        chk("t5_ign", pend, 0);
        cyc(1, 4'b1011, 4'h0, 4'h0, 1);
        chk("t5_drain", out_valid, 0);
        cyc(1, 4'b1011, 4'h0, 4'h0, 1);
        chk("t5_none", out_valid, 0);
        dv[2] = 32'h77;
        cyc(1, 4'hF, 4'b0100, 4'h0, 1);
        cyc(1, 4'hF, 4'h0, 4'h0, 1);
        chk("t5_valid", out_valid, 1);
        chk("t5_data",  out_data,  32'h77);
        chk("t5_chan",  out_chan,  2);

        // Reset mid-transfer
        for (int k = 0; k < NCH; k++) dv[k] = 32'hC0 + k;
        cyc(1, 4'hF, 4'hF, 4'h0, 0);
        cyc(1, 4'hF, 4'h0, 4'h0, 1);
        chk("t6_valid", out_valid, 1);
        chk("t6_pend",  pend,      4'b0111);
        cyc(0, 4'hF, 4'h0, 4'h0, 0);
        chk("t6_rvalid", out_valid, 0);
        chk("t6_rdata",  out_data,  0);
        chk("t6_rchan",  out_chan,  0);
        chk("t6_rpend",  pend,      0);
        for (int j = 0; j < 4; j++) begin
            cyc(1, 4'hF, 4'h0, 4'h0, 1);
            chk("t6_stale", out_valid, 0);
        end

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [NCH-1:0] en;
            logic [NCH-1:0] upd;
            logic [NCH-1:0] clr;
            for (int k = 0; k < NCH; k++) dv[k] = $urandom;
            en  = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : 4'hF;
            upd = NCH'($urandom) & NCH'($urandom);
            clr = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
            cyc(($urandom_range(0, 299) != 0), en, upd, clr, ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
